// File: rtl/icnbc_pkg.sv
// Shared types and width helpers for the icnbc sweep controller and the search engine.
package icnbc_pkg;

   // Sweep sequencer states.
   typedef enum logic [2:0] {
      StIdle,
      StRstEng,
      StLaunch,
      StWait,
      StEmit,
      StFinish
   } sweep_state_e;

   // Width of a minimum-distance value for an N-bit code (0..N inclusive).
   function automatic int unsigned ld_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Codebook-size width: at least n+1 bits to hold 2^n, never below the engine's 10-bit address.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n + 1 > 10) ? n + 1 : 10;
   endfunction

   // Code width the engine is built with.
   localparam int unsigned CodeN   = 3;
   localparam int unsigned RecLdW  = ld_width(CodeN);
   localparam int unsigned RecCntW = cnt_width(CodeN);

   // One result record per searched distance.
   typedef struct packed {
      logic [RecLdW-1:0]  ld;
      logic [RecCntW-1:0] count;
      logic               timeout;
   } sweep_rec_t;

endpackage

// File: rtl/icnbc_watchdog.sv
// Per-search watchdog: counts enabled cycles since the last clear and flags expiry on the
// LIMIT-th enabled cycle.
module icnbc_watchdog #(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(LIMIT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && (cnt_q == CntW'(LIMIT - 1));

   // Clear wins over counting; saturate once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/icnbc_sweep_ctrl.sv
// Sweep sequencer: runs one code search per minimum-distance value in [lo, hi] and emits a
// result record for each. Optional watchdog enabled by defining ICNBC_SWEEP_TIMEOUT_EN.
module icnbc_sweep_ctrl
   import icnbc_pkg::*;
#(
   parameter int unsigned N           = CodeN,
   parameter int unsigned LD_W        = ld_width(N),
   parameter int unsigned CNT_W       = cnt_width(N),
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [LD_W-1:0]  cfg_ld_lo_i,
   input  logic [LD_W-1:0]  cfg_ld_hi_i,
   input  logic             abort_i,
   output logic             eng_rst_o,
   output logic             eng_start_o,
   output logic [LD_W-1:0]  eng_min_ld_o,
   input  logic             eng_done_i,
   input  logic [CNT_W-1:0] eng_count_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [LD_W-1:0]  res_ld_o,
   output logic [CNT_W-1:0] res_count_o,
   output logic             res_timeout_o,
   output logic             busy_o,
   output logic             sweep_done_o,
   output logic             cfg_err_o
);

   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be non-zero");
   end

   sweep_state_e    state_q, state_d;
   logic [LD_W-1:0] cur_ld_q, cur_ld_d;
   logic [LD_W-1:0] hi_q, hi_d;
   sweep_rec_t      res_q, res_d;
   logic            cfg_err_q, cfg_err_d;
   // Extra engine reset outside RST_ENG (abort or watchdog kill).
   logic            kill_rst_q, kill_rst_d;

`ifdef ICNBC_SWEEP_TIMEOUT_EN
   logic wd_clr, wd_en, wd_expire;

   icnbc_watchdog #(
      .LIMIT (TIMEOUT_CYC)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );
`endif

   // Next-state logic; abort overrides everything once a sweep is running.
   always_comb begin
      state_d    = state_q;
      cur_ld_d   = cur_ld_q;
      hi_d       = hi_q;
      res_d      = res_q;
      cfg_err_d  = 1'b0;
      kill_rst_d = 1'b0;
`ifdef ICNBC_SWEEP_TIMEOUT_EN
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
`endif
      if (abort_i && (state_q != StIdle) && (state_q != StFinish)) begin
         state_d    = StFinish;
         kill_rst_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_valid_i) begin
                  if (cfg_ld_lo_i > cfg_ld_hi_i) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     cur_ld_d = cfg_ld_lo_i;
                     hi_d     = cfg_ld_hi_i;
                     state_d  = StRstEng;
                  end
               end
            end
            StRstEng: state_d = StLaunch;
            StLaunch: begin
`ifdef ICNBC_SWEEP_TIMEOUT_EN
               wd_clr = 1'b1;
`endif
               state_d = StWait;
            end
            StWait: begin
`ifdef ICNBC_SWEEP_TIMEOUT_EN
               wd_en = 1'b1;
`endif
               if (eng_done_i) begin
                  res_d   = '{ld: cur_ld_q, count: eng_count_i, timeout: 1'b0};
                  state_d = StEmit;
               end
`ifdef ICNBC_SWEEP_TIMEOUT_EN
               else if (wd_expire) begin
                  res_d      = '{ld: cur_ld_q, count: '0, timeout: 1'b1};
                  kill_rst_d = 1'b1;
                  state_d    = StEmit;
               end
`endif
            end
            StEmit: begin
               if (res_ready_i) begin
                  // Compare before incrementing so hi = all-ones terminates without wrapping.
                  if (cur_ld_q == hi_q) begin
                     state_d = StFinish;
                  end else begin
                     cur_ld_d = cur_ld_q + LD_W'(1);
                     state_d  = StRstEng;
                  end
               end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cur_ld_q   <= '0;
         hi_q       <= '0;
         res_q      <= '0;
         cfg_err_q  <= 1'b0;
         kill_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_ld_q   <= cur_ld_d;
         hi_q       <= hi_d;
         res_q      <= res_d;
         cfg_err_q  <= cfg_err_d;
         kill_rst_q <= kill_rst_d;
      end
   end

   assign cfg_ready_o   = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign eng_rst_o     = (state_q == StRstEng) || kill_rst_q;
   assign eng_start_o   = (state_q == StLaunch);
   assign eng_min_ld_o  = cur_ld_q;
   assign res_valid_o   = (state_q == StEmit);
   assign res_ld_o      = res_q.ld;
   assign res_count_o   = res_q.count;
   assign res_timeout_o = res_q.timeout;
   assign sweep_done_o  = (state_q == StFinish);
   assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_icnbc_sweep_ctrl.sv
// Self-checking bench for icnbc_sweep_ctrl with a behavioural engine and a record scoreboard.
module tb_icnbc_sweep_ctrl;

   localparam int unsigned LdW  = 2;
   localparam int unsigned CntW = 10;

   typedef struct packed {
      logic [LdW-1:0]  ld;
      logic [CntW-1:0] count;
      logic            timeout;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready_o;
   logic [LdW-1:0]  cfg_ld_lo = '0;
   logic [LdW-1:0]  cfg_ld_hi = '0;
   logic            abort = 1'b0;
   logic            eng_rst_o, eng_start_o;
   logic [LdW-1:0]  eng_min_ld_o;
   logic            eng_done = 1'b0;
   logic [CntW-1:0] eng_count = '0;
   logic            res_valid_o;
   logic            res_ready = 1'b1;
   logic [LdW-1:0]  res_ld_o;
   logic [CntW-1:0] res_count_o;
   logic            res_timeout_o, busy_o, sweep_done_o, cfg_err_o;

   rec_t exp_q[$];
   int   n_vec = 0, n_miss = 0;
   int   n_start = 0, n_done = 0, n_cfg_err = 0;

   bit             eng_auto = 1'b1;
   bit             hang_en = 1'b0;
   logic [LdW-1:0] hang_ld = '0;
   bit             eng_pend = 1'b0;
   int             eng_delay = 0;
   logic [LdW-1:0] eng_ld = '0;

   always #5 clk = ~clk;

   icnbc_sweep_ctrl #(
      .N           (3),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid_i   (cfg_valid),
      .cfg_ready_o   (cfg_ready_o),
      .cfg_ld_lo_i   (cfg_ld_lo),
      .cfg_ld_hi_i   (cfg_ld_hi),
      .abort_i       (abort),
      .eng_rst_o     (eng_rst_o),
      .eng_start_o   (eng_start_o),
      .eng_min_ld_o  (eng_min_ld_o),
      .eng_done_i    (eng_done),
      .eng_count_i   (eng_count),
      .res_valid_o   (res_valid_o),
      .res_ready_i   (res_ready),
      .res_ld_o      (res_ld_o),
      .res_count_o   (res_count_o),
      .res_timeout_o (res_timeout_o),
      .busy_o        (busy_o),
      .sweep_done_o  (sweep_done_o),
      .cfg_err_o     (cfg_err_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine model: codebook size halves per distance step (ld=1 -> 8).
   function automatic logic [CntW-1:0] count_for(input logic [LdW-1:0] ld);
      return CntW'(16 >> ld);
   endfunction

   function automatic rec_t mk_rec(input int ld, input int cnt, input bit to);
      rec_t r;
      r.ld      = LdW'(ld);
      r.count   = CntW'(cnt);
      r.timeout = to;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return eng_start_o;
         1:       return res_valid_o;
         2:       return sweep_done_o;
         default: return cfg_ready_o;
      endcase
   endfunction

   // Bounded wait; an expired bound shows up as a failed comparison.
   task automatic wait_sig(input string tag, input int which, input int limit);
      for (int i = 0; i < limit && !sig(which); i++) tick();
      check_eq(tag, sig(which), 1);
   endtask

   task automatic send_job(input int lo, input int hi);
      wait_sig("cfg_ready_wait", 3, 50);
      cfg_valid = 1'b1;
      cfg_ld_lo = LdW'(lo);
      cfg_ld_hi = LdW'(hi);
      tick();
      cfg_valid = 1'b0;
   endtask

   // Output monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (eng_start_o)  n_start++;
         if (sweep_done_o) n_done++;
         if (cfg_err_o)    n_cfg_err++;
         if (res_valid_o && res_ready) begin
            check_eq("rec_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               rec_t r;
               r = exp_q.pop_front();
               check_eq("rec_ld", res_ld_o, r.ld);
               check_eq("rec_count", res_count_o, r.count);
               check_eq("rec_timeout", res_timeout_o, r.timeout);
            end
         end
      end
   end

   // Behavioural engine: done two cycles after start unless told to hang.
   always @(negedge clk) begin
      if (eng_auto) begin
         eng_done = 1'b0;
         if (rst || eng_rst_o) eng_pend = 1'b0;
         if (eng_start_o) begin
            eng_pend  = 1'b1;
            eng_delay = 2;
            eng_ld    = eng_min_ld_o;
         end else if (eng_pend) begin
            check_eq("min_ld_stable", eng_min_ld_o, eng_ld);
            if (eng_delay > 0) begin
               eng_delay--;
            end else if (!(hang_en && eng_ld == hang_ld)) begin
               eng_done  = 1'b1;
               eng_count = count_for(eng_ld);
               eng_pend  = 1'b0;
            end
         end
      end
   end

   initial begin
      int s0, d0, e0, lat;

      // Reset state.
      repeat (3) tick();
      check_eq("rst_cfg_ready", cfg_ready_o, 1);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_outs", {eng_rst_o, eng_start_o, eng_min_ld_o, res_valid_o, res_ld_o,
                            res_count_o, res_timeout_o, sweep_done_o, cfg_err_o}, 0);
      rst = 1'b0;
      tick();

      // 1: sweep 1..3, including hi = all-ones.
      exp_q.push_back(mk_rec(1, 8, 1'b0));
      exp_q.push_back(mk_rec(2, 4, 1'b0));
      exp_q.push_back(mk_rec(3, 2, 1'b0));
      d0 = n_done;
      send_job(1, 3);
      check_eq("t1_eng_rst", eng_rst_o, 1);
      check_eq("t1_busy", busy_o, 1);
      tick();
      check_eq("t1_start_lat", eng_start_o, 1);
      check_eq("t1_min_ld", eng_min_ld_o, 1);
      wait_sig("t1_sweep_done", 2, 200);
      tick();
      check_eq("t1_q_empty", exp_q.size(), 0);
      check_eq("t1_done_cnt", n_done - d0, 1);
      check_eq("t1_idle", busy_o, 0);

      // 2: lo > hi is rejected.
      s0 = n_start; d0 = n_done; e0 = n_cfg_err;
      send_job(2, 1);
      check_eq("t2_cfg_err", cfg_err_o, 1);
      check_eq("t2_cfg_ready", cfg_ready_o, 1);
      repeat (5) tick();
      check_eq("t2_no_start", n_start - s0, 0);
      check_eq("t2_no_done", n_done - d0, 0);
      check_eq("t2_err_once", n_cfg_err - e0, 1);
      check_eq("t2_ready_after", cfg_ready_o, 1);

      // 3: single search with back-pressure.
      res_ready = 1'b0;
      exp_q.push_back(mk_rec(2, 4, 1'b0));
      s0 = n_start;
      send_job(2, 2);
      wait_sig("t3_valid", 1, 100);
      for (int i = 0; i < 10; i++) begin
         check_eq("t3_hold", {res_valid_o, res_ld_o, res_count_o, res_timeout_o},
                  {1'b1, 2'd2, 10'd4, 1'b0});
         tick();
      end
      check_eq("t3_one_start", n_start - s0, 1);
      res_ready = 1'b1;
      tick();
      check_eq("t3_sweep_done", sweep_done_o, 1);
      tick();
      check_eq("t3_q_empty", exp_q.size(), 0);

      // 4: abort coincident with eng_done in the second search.
      eng_auto = 1'b0;
      eng_done = 1'b0;
      exp_q.push_back(mk_rec(1, 8, 1'b0));
      send_job(1, 3);
      wait_sig("t4_start1", 0, 20);
      tick();
      tick();
      eng_done  = 1'b1;
      eng_count = 10'd8;
      tick();
      eng_done = 1'b0;
      wait_sig("t4_start2", 0, 20);
      check_eq("t4_min_ld2", eng_min_ld_o, 2);
      tick();
      tick();
      eng_done  = 1'b1;
      eng_count = 10'd4;
      abort     = 1'b1;
      tick();
      eng_done = 1'b0;
      abort    = 1'b0;
      check_eq("t4_eng_rst", eng_rst_o, 1);
      check_eq("t4_no_valid", res_valid_o, 0);
      check_eq("t4_sweep_done", sweep_done_o, 1);
      tick();
      check_eq("t4_idle", busy_o, 0);
      check_eq("t4_cfg_ready", cfg_ready_o, 1);
      eng_auto = 1'b1;
      exp_q.push_back(mk_rec(3, 2, 1'b0));
      send_job(3, 3);
      wait_sig("t4_new_done", 2, 100);
      tick();
      check_eq("t4_q_empty", exp_q.size(), 0);

`ifdef ICNBC_SWEEP_TIMEOUT_EN
      // 5: engine hangs on ld=2; watchdog kills it and the sweep continues.
      hang_en = 1'b1;
      hang_ld = 2'd2;
      exp_q.push_back(mk_rec(1, 8, 1'b0));
      exp_q.push_back(mk_rec(2, 0, 1'b1));
      exp_q.push_back(mk_rec(3, 2, 1'b0));
      send_job(1, 3);
      wait_sig("t5_start1", 0, 20);
      tick();
      wait_sig("t5_start2", 0, 40);
      check_eq("t5_min_ld2", eng_min_ld_o, 2);
      lat = 0;
      while (!res_valid_o && lat < 100) begin
         tick();
         lat++;
      end
      check_eq("t5_latency", lat, 17);
      check_eq("t5_timeout_flag", res_timeout_o, 1);
      check_eq("t5_kill_rst", eng_rst_o, 1);
      wait_sig("t5_sweep_done", 2, 200);
      tick();
      check_eq("t5_q_empty", exp_q.size(), 0);
      hang_en = 1'b0;
`endif

      // 6: reset while a record is pending.
      res_ready = 1'b0;
      send_job(1, 1);
      wait_sig("t6_valid", 1, 100);
      rst = 1'b1;
      tick();
      check_eq("t6_cfg_ready", cfg_ready_o, 1);
      check_eq("t6_outs", {busy_o, eng_rst_o, eng_start_o, eng_min_ld_o, res_valid_o, res_ld_o,
                           res_count_o, res_timeout_o, sweep_done_o, cfg_err_o}, 0);
      rst = 1'b0;
      res_ready = 1'b1;
      repeat (3) tick();
      check_eq("t6_stay_idle", busy_o, 0);
      check_eq("final_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
